// File: rtl/led_scan_arb.sv
// led_scan_arb: two-source display arbiter with hold-off, driving an
// 8-digit multiplexed 7-segment display (all outputs active-low).
module led_scan_arb #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned HOLD_CYC = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [31:0] data_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [31:0] data_b,
  output logic        ack_b,
  output logic [7:0]  led_en,
  output logic [6:0]  led_seg,
  output logic        led_dp,
  output logic [1:0]  owner
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  // State encoding doubles as the owner code.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD_A = 2'b01,
    HOLD_B = 2'b10
  } state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  state_e            state_q, state_d;
  src_e              last_q, last_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic [31:0]       disp_q, disp_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        led_en_q, led_en_d;
  logic [6:0]        led_seg_q, led_seg_d;
  logic              led_dp_q, led_dp_d;

  // Hex digit to active-low {ca..cg} segment pattern.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'b1111111;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Arbitration: grants, same-owner refreshes, hold counter and capture.
  always_comb begin
    logic va, vb, grant_a, grant_b, refresh_a, refresh_b, hold_last;
    state_d   = state_q;
    last_d    = last_q;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    disp_d    = disp_q;
    hold_d    = hold_q;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    refresh_a = 1'b0;
    refresh_b = 1'b0;
    // A request seen while its ack is out belongs to the capture just made.
    va        = req_a & ~ack_a_q;
    vb        = req_b & ~ack_b_q;
    hold_last = (hold_q == HOLD_LAST);

    case (state_q)
      IDLE: begin
        if (va && vb) begin
          if (last_q == SRC_B) grant_a = 1'b1;
          else                 grant_b = 1'b1;
        end else if (va) begin
          grant_a = 1'b1;
        end else if (vb) begin
          grant_b = 1'b1;
        end
      end
      HOLD_A: begin
        hold_d = hold_last ? hold_q : hold_q + HOLD_W'(1);
        if (vb && hold_last) grant_b   = 1'b1;
        else if (va)         refresh_a = 1'b1;
      end
      HOLD_B: begin
        hold_d = hold_last ? hold_q : hold_q + HOLD_W'(1);
        if (va && hold_last) grant_a   = 1'b1;
        else if (vb)         refresh_b = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (grant_a) begin
      state_d = HOLD_A;
      last_d  = SRC_A;
      hold_d  = '0;
    end
    if (grant_b) begin
      state_d = HOLD_B;
      last_d  = SRC_B;
      hold_d  = '0;
    end
    if (grant_a || refresh_a) begin
      disp_d  = data_a;
      ack_a_d = 1'b1;
    end
    if (grant_b || refresh_b) begin
      disp_d  = data_b;
      ack_b_d = 1'b1;
    end
  end

  // Digit scan: dwell counter, digit index and registered display drive.
  always_comb begin
    logic scan_last;
    scan_last = (scan_q == SCAN_LAST);
    scan_d    = scan_last ? '0 : scan_q + SCAN_W'(1);
    idx_d     = scan_last ? idx_q + 3'd1 : idx_q;
    led_en_d  = ~(8'h01 << idx_q);
    led_seg_d = seg_decode(disp_q[{idx_q, 2'b00} +: 4]);
    led_dp_d  = ~((idx_q == 3'd0) && (state_q == HOLD_B));
  end

  // All state, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= SRC_B;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      disp_q    <= '0;
      hold_q    <= '0;
      scan_q    <= '0;
      idx_q     <= '0;
      led_en_q  <= '1;
      led_seg_q <= '1;
      led_dp_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      disp_q    <= disp_d;
      hold_q    <= hold_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      led_en_q  <= led_en_d;
      led_seg_q <= led_seg_d;
      led_dp_q  <= led_dp_d;
    end
  end

  assign ack_a   = ack_a_q;
  assign ack_b   = ack_b_q;
  assign led_en  = led_en_q;
  assign led_seg = led_seg_q;
  assign led_dp  = led_dp_q;
  assign owner   = state_q;

endmodule
